multiply_backward: RTL and testbench

//   Backward (gradient) pass for the two-operand multiply stage. Latches the

---
 rtl/multiply_backward_if.sv | 32 +++
 rtl/multiply_backward.sv | 146 ++++++++++++++
 tb/tb_multiply_backward.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/multiply_backward_if.sv
// Handshake bundle for multiply_backward: operand pair in, error in, gradients out.
// GW follows the MULTIPLY_BACKWARD_SATURATE_EN build option so that both ends agree.
interface multiply_backward_if #(
  parameter int ARGW = 16,
  parameter int ERRW = 16
);
`ifdef MULTIPLY_BACKWARD_SATURATE_EN
  localparam int GW = ERRW;
`else
  localparam int GW = ARGW + ERRW;
`endif

  logic [2*ARGW-1:0] arg_data;
  logic              arg_valid;
  logic              arg_ready;
  logic [ERRW-1:0]   err_data;
  logic              err_valid;
  logic              err_ready;
  logic [2*GW-1:0]   grad_data;
  logic              grad_valid;
  logic              grad_ready;

  modport master (
    output arg_data, arg_valid, err_data, err_valid, grad_ready,
    input  arg_ready, err_ready, grad_data, grad_valid
  );

  modport slave (
    input  arg_data, arg_valid, err_data, err_valid, grad_ready,
    output arg_ready, err_ready, grad_data, grad_valid
  );
endinterface

// File: rtl/multiply_backward.sv
// Backward pass of the two-operand multiply: grad0 = err*arg1, grad1 = err*arg0.
// One signed multiplier is time-shared over two cycles (MUL0 then MUL1).
// Build option MULTIPLY_BACKWARD_SATURATE_EN: products are shifted right by FRAC
// (floor) and saturated to ERRW signed bits; otherwise full-precision products.
module multiply_backward #(
  parameter int ARGW = 16,
`ifdef MULTIPLY_BACKWARD_SATURATE_EN
  parameter int FRAC = 8,
`endif
  parameter int ERRW = 16
) (
  input logic                clk,
  input logic                rst,
  multiply_backward_if.slave bus
);
  localparam int PW = ARGW + ERRW;
`ifdef MULTIPLY_BACKWARD_SATURATE_EN
  localparam int GW = ERRW;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-ERRW+1){1'b0}}, {(ERRW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-ERRW+1){1'b1}}, {(ERRW-1){1'b0}}};

  // Scale a raw product down by FRAC fraction bits, then clamp to the ERRW range.
  function automatic logic [GW-1:0] scale_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] sh;
    sh = p >>> FRAC;
    if (sh > SAT_MAX) begin
      return SAT_MAX[GW-1:0];
    end else if (sh < SAT_MIN) begin
      return SAT_MIN[GW-1:0];
    end else begin
      return sh[GW-1:0];
    end
  endfunction
`else
  localparam int GW = PW;
`endif

  typedef enum logic [2:0] {
    ST_ARG  = 3'd0,
    ST_ERR  = 3'd1,
    ST_MUL0 = 3'd2,
    ST_MUL1 = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic signed [ARGW-1:0] arg0_q, arg0_d;
  logic signed [ARGW-1:0] arg1_q, arg1_d;
  logic signed [ERRW-1:0] err_q, err_d;
  logic [GW-1:0]          grad0_q, grad0_d;
  logic [GW-1:0]          grad1_q, grad1_d;

  logic signed [ARGW-1:0] mul_arg_s;
  logic signed [PW-1:0]   prod_s;
  logic [GW-1:0]          prod_fmt_s;

  // Shared multiplier: arg1 during MUL0 (grad0), arg0 otherwise (grad1 in MUL1).
  always_comb begin
    mul_arg_s = arg0_q;
    if (state_q == ST_MUL0) begin
      mul_arg_s = arg1_q;
    end else begin
      mul_arg_s = arg0_q;
    end
    prod_s = mul_arg_s * err_q;
`ifdef MULTIPLY_BACKWARD_SATURATE_EN
    prod_fmt_s = scale_sat(prod_s);
`else
    prod_fmt_s = prod_s;
`endif
  end

  // Next-state and datapath update for the ARG->ERR->MUL0->MUL1->OUT sequence.
  always_comb begin
    state_d = state_q;
    arg0_d  = arg0_q;
    arg1_d  = arg1_q;
    err_d   = err_q;
    grad0_d = grad0_q;
    grad1_d = grad1_q;
    case (state_q)
      ST_ARG: begin
        if (bus.arg_valid) begin
          arg0_d  = bus.arg_data[ARGW-1:0];
          arg1_d  = bus.arg_data[2*ARGW-1:ARGW];
          state_d = ST_ERR;
        end else begin
          state_d = ST_ARG;
        end
      end
      ST_ERR: begin
        if (bus.err_valid) begin
          err_d   = bus.err_data;
          state_d = ST_MUL0;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_MUL0: begin
        grad0_d = prod_fmt_s;
        state_d = ST_MUL1;
      end
      ST_MUL1: begin
        grad1_d = prod_fmt_s;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.grad_ready) begin
          state_d = ST_ARG;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ARG;
      end
    endcase
  end

  // Moore outputs decoded from registered state; gradients come straight from flops.
  always_comb begin
    bus.arg_ready  = (state_q == ST_ARG);
    bus.err_ready  = (state_q == ST_ERR);
    bus.grad_valid = (state_q == ST_OUT);
    bus.grad_data  = {grad1_q, grad0_q};
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARG;
      arg0_q  <= '0;
      arg1_q  <= '0;
      err_q   <= '0;
      grad0_q <= '0;
      grad1_q <= '0;
    end else begin
      state_q <= state_d;
      arg0_q  <= arg0_d;
      arg1_q  <= arg1_d;
      err_q   <= err_d;
      grad0_q <= grad0_d;
      grad1_q <= grad1_d;
    end
  end
endmodule

// File: tb/tb_multiply_backward.sv
// Self-checking bench for multiply_backward: directed scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_multiply_backward;
  localparam int ARGW = 16;
  localparam int ERRW = 16;
`ifdef MULTIPLY_BACKWARD_SATURATE_EN
  localparam int GW   = ERRW;
  localparam int FRAC = 8;
`else
  localparam int GW   = ARGW + ERRW;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multiply_backward_if #(.ARGW(ARGW), .ERRW(ERRW)) bus ();
  multiply_backward #(.ARGW(ARGW), .ERRW(ERRW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference: plain integer products, optionally floor-scaled and clamped.
  function automatic logic [2*GW-1:0] model(input logic [2*ARGW-1:0] a, input logic [ERRW-1:0] e);
    longint ev, a0, a1, g0, g1;
    ev = longint'($signed(e));
    a0 = longint'($signed(a[ARGW-1:0]));
    a1 = longint'($signed(a[2*ARGW-1:ARGW]));
    g0 = ev * a1;
    g1 = ev * a0;
`ifdef MULTIPLY_BACKWARD_SATURATE_EN
    g0 = g0 >>> FRAC;
    g1 = g1 >>> FRAC;
    if (g0 > 64'sd32767) g0 = 64'sd32767; else if (g0 < -64'sd32768) g0 = -64'sd32768;
    if (g1 > 64'sd32767) g1 = 64'sd32767; else if (g1 < -64'sd32768) g1 = -64'sd32768;
`endif
    return {g1[GW-1:0], g0[GW-1:0]};
  endfunction

  // Offer an operand pair until accepted; called and returns on a falling edge.
  task automatic send_arg(input logic [2*ARGW-1:0] d, output bit ok);
    ok = 1'b0;
    bus.arg_data  = d;
    bus.arg_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.arg_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    bus.arg_valid = 1'b0;
  endtask

  task automatic send_err(input logic [ERRW-1:0] d, output bit ok);
    ok = 1'b0;
    bus.err_data  = d;
    bus.err_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus.err_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    bus.err_valid = 1'b0;
  endtask

  // Count falling edges until grad_valid, bounded by max.
  task automatic wait_grad(input int max, output int lat);
    lat = 0;
    while (bus.grad_valid !== 1'b1 && lat < max) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_grad();
    bus.grad_ready = 1'b1;
    @(negedge clk);
    bus.grad_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.arg_valid = 1'b0; bus.err_valid = 1'b0; bus.grad_ready = 1'b0;
    bus.arg_data = '0; bus.err_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.arg_ready !== 1'b1) begin errors++; $display("FAIL reset_arg_ready got %b exp 1", bus.arg_ready); end
    checks++; if (bus.err_ready !== 1'b0) begin errors++; $display("FAIL reset_err_ready got %b exp 0", bus.err_ready); end
    checks++; if (bus.grad_valid !== 1'b0) begin errors++; $display("FAIL reset_grad_valid got %b exp 0", bus.grad_valid); end
    checks++; if (bus.grad_data !== '0) begin errors++; $display("FAIL reset_grad_data got %h exp 0", bus.grad_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Scenarios 1 and 2; grad_valid expected in the third cycle after the err handshake cycle.
  task automatic test_directed();
    logic [2*ARGW-1:0] args [2];
    logic [ERRW-1:0]   errs [2];
    logic [2*GW-1:0]   lits [2];
    bit ok_a, ok_e;
    int lat;
    args[0] = 32'h0003_0002; errs[0] = 16'h0010; lits[0] = {32'h0000_0020, 32'h0000_0030};
    args[1] = 32'h0000_FFFF; errs[1] = 16'h0004; lits[1] = {32'hFFFF_FFFC, 32'h0000_0000};
    for (int k = 0; k < 2; k++) begin
      send_arg(args[k], ok_a);
      send_err(errs[k], ok_e);
      checks++; if (!(ok_a && ok_e)) begin errors++; $display("FAIL directed%0d_handshake got %b%b exp 11", k, ok_a, ok_e); end
      wait_grad(20, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL directed%0d_latency got %0d exp 2", k, lat); end
      checks++; if (bus.grad_data !== model(args[k], errs[k])) begin errors++; $display("FAIL directed%0d_data got %h exp %h", k, bus.grad_data, model(args[k], errs[k])); end
`ifndef MULTIPLY_BACKWARD_SATURATE_EN
      checks++; if (bus.grad_data !== lits[k]) begin errors++; $display("FAIL directed%0d_literal got %h exp %h", k, bus.grad_data, lits[k]); end
`endif
      pop_grad();
      checks++; if (bus.grad_valid !== 1'b0 || bus.arg_ready !== 1'b1) begin errors++; $display("FAIL directed%0d_release got v=%b r=%b exp v=0 r=1", k, bus.grad_valid, bus.arg_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [2*GW-1:0] exp;
    bit ok_a, ok_e;
    int lat;
    exp = model(32'h0080_0080, 16'h0100);
    send_arg(32'h0080_0080, ok_a);
    send_err(16'h0100, ok_e);
    wait_grad(20, lat);
    checks++; if (bus.grad_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b exp 1", bus.grad_valid); end
`ifndef MULTIPLY_BACKWARD_SATURATE_EN
    checks++; if (bus.grad_data !== {32'h0000_8000, 32'h0000_8000}) begin errors++; $display("FAIL bp_literal got %h exp 0000800000008000", bus.grad_data); end
`endif
    bus.arg_valid = 1'b1; bus.arg_data = 32'h1111_2222;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.grad_valid !== 1'b1 || bus.grad_data !== exp) begin errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h", bus.grad_valid, bus.grad_data, exp); end
      checks++; if (bus.arg_ready !== 1'b0) begin errors++; $display("FAIL bp_arg_ready got %b exp 0", bus.arg_ready); end
    end
    bus.arg_valid = 1'b0;
    pop_grad();
    checks++; if (bus.arg_ready !== 1'b1 || bus.grad_valid !== 1'b0) begin errors++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", bus.arg_ready, bus.grad_valid); end
  endtask

  task automatic test_reset_midcompute();
    bit ok_a, ok_e;
    int lat;
    send_arg(32'h0005_0007, ok_a);
    send_err(16'h0123, ok_e);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.grad_valid !== 1'b0 || bus.grad_data !== '0) begin errors++; $display("FAIL midrst_out got v=%b d=%h exp v=0 d=0", bus.grad_valid, bus.grad_data); end
    checks++; if (bus.arg_ready !== 1'b1 || bus.err_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got a=%b e=%b exp a=1 e=0", bus.arg_ready, bus.err_ready); end
    rst = 1'b0;
    @(negedge clk);
    send_arg(32'h0003_0002, ok_a);
    send_err(16'h0010, ok_e);
    wait_grad(20, lat);
    checks++; if (lat !== 2 || bus.grad_data !== model(32'h0003_0002, 16'h0010)) begin errors++; $display("FAIL midrst_after got lat=%0d d=%h exp lat=2 d=%h", lat, bus.grad_data, model(32'h0003_0002, 16'h0010)); end
    pop_grad();
  endtask

  task automatic test_err_first();
    bus.err_valid = 1'b1;
    bus.err_data  = 16'h1234;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (bus.err_ready !== 1'b0 || bus.grad_valid !== 1'b0) begin errors++; $display("FAIL errfirst got er=%b gv=%b exp er=0 gv=0", bus.err_ready, bus.grad_valid); end
    end
    bus.err_valid = 1'b0;
    @(negedge clk);
  endtask

`ifdef MULTIPLY_BACKWARD_SATURATE_EN
  task automatic test_saturate();
    logic [2*ARGW-1:0] args [3];
    logic [ERRW-1:0]   errs [3];
    logic [GW-1:0]     g0s  [3];
    bit ok_a, ok_e;
    int lat;
    args[0] = 32'h7FFF_0001; errs[0] = 16'h7FFF; g0s[0] = 16'h7FFF;
    args[1] = 32'h0100_0001; errs[1] = 16'h0200; g0s[1] = 16'h0200;
    args[2] = 32'h8000_0001; errs[2] = 16'h7FFF; g0s[2] = 16'h8000;
    for (int k = 0; k < 3; k++) begin
      send_arg(args[k], ok_a);
      send_err(errs[k], ok_e);
      wait_grad(20, lat);
      checks++; if (lat !== 2 || bus.grad_data[GW-1:0] !== g0s[k]) begin errors++; $display("FAIL sat%0d got lat=%0d g0=%h exp lat=2 g0=%h", k, lat, bus.grad_data[GW-1:0], g0s[k]); end
      pop_grad();
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [2*ARGW-1:0] a;
    logic [ERRW-1:0]   e;
    logic [2*GW-1:0]   exp;
    bit ok_a, ok_e;
    int lat, stall;
    for (int n = 0; n < 25; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: e = 16'h8000;
        1: e = 16'h7FFF;
        default: e = $urandom;
      endcase
      if (n == 3) a = 32'h8000_8000;
      exp = model(a, e);
      stall = $urandom_range(0, 3);
      send_arg(a, ok_a);
      send_err(e, ok_e);
      wait_grad(20, lat);
      checks++; if (lat !== 2 || bus.grad_data !== exp) begin errors++; $display("FAIL rand%0d got lat=%0d d=%h exp lat=2 d=%h", n, lat, bus.grad_data, exp); end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++; if (bus.grad_valid !== 1'b1 || bus.grad_data !== exp) begin errors++; $display("FAIL rand%0d_stall got v=%b d=%h exp v=1 d=%h", n, bus.grad_valid, bus.grad_data, exp); end
      end
      pop_grad();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midcompute();
    test_err_first();
`ifdef MULTIPLY_BACKWARD_SATURATE_EN
    test_saturate();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
